// File: rtl/aes_key_sched_ctrl.sv
// rtl/aes_key_sched_ctrl.sv - iterative AES-128 key expansion sequencer with round-key register file.
// Optional round-key stream outputs are enabled by defining AES_KEY_STREAM_EN.

module aes_subkey (
   input  logic [127:0] key_i,
   input  logic [7:0]   rcon_i,
   output logic [127:0] key_o
);
   localparam logic [2047:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic logic [7:0] sbox(input logic [7:0] x);
      return SBOX[2047 - 8*int'(x) -: 8];
   endfunction

   logic [31:0] w0, w1, w2, w3, t;

   always_comb begin
      w0 = key_i[127:96];
      w1 = key_i[95:64];
      w2 = key_i[63:32];
      w3 = key_i[31:0];
      // RotWord then SubWord on the last word, rcon folded into the top byte
      t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^ {rcon_i, 24'h0};
      key_o = {w0 ^ t, w1 ^ w0 ^ t, w2 ^ w1 ^ w0 ^ t, w3 ^ w2 ^ w1 ^ w0 ^ t};
   end
endmodule

module aes_key_sched_ctrl #(
   parameter int NR = 10
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [127:0] key_in,
   output logic         busy,
   output logic         ready,
   output logic         done,
   input  logic [3:0]   rk_addr,
   output logic [127:0] rk_data
`ifdef AES_KEY_STREAM_EN
   ,output logic         rk_strm_valid
   ,output logic [3:0]   rk_strm_idx
   ,output logic [127:0] rk_strm_data
`endif
);
   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_EXPAND = 2'd1;
   localparam logic [1:0] S_FINISH = 2'd2;

   logic [1:0]   state_q, state_d;
   logic [3:0]   cnt_q, cnt_d;
   logic [7:0]   rcon_q, rcon_d;
   logic         busy_q, busy_d;
   logic         ready_q, ready_d;
   logic         done_q, done_d;
   logic [127:0] rk_q [0:NR];

   logic         rk_we;
   logic [3:0]   rk_widx;
   logic [127:0] rk_wdata;
   logic [3:0]   prev_idx;
   logic [127:0] prev_key;
   logic [127:0] next_key;
   logic [7:0]   rcon_next;

   aes_subkey u_subkey (
      .key_i  (prev_key),
      .rcon_i (rcon_q),
      .key_o  (next_key)
   );

   assign rcon_next = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1B : 8'h00);
   assign prev_idx  = cnt_q - 4'd1;

   always_comb begin
      prev_key = '0;
      for (int i = 0; i <= NR; i++) begin
         if (prev_idx == 4'(i)) prev_key = rk_q[i];
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      rcon_d   = rcon_q;
      busy_d   = busy_q;
      ready_d  = ready_q;
      done_d   = done_q;
      rk_we    = 1'b0;
      rk_widx  = cnt_q;
      rk_wdata = next_key;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d  = S_EXPAND;
               cnt_d    = 4'd1;
               rcon_d   = 8'h01;
               busy_d   = 1'b1;
               ready_d  = 1'b0;
               rk_we    = 1'b1;
               rk_widx  = 4'd0;
               rk_wdata = key_in;
            end
         end
         S_EXPAND: begin
            rk_we  = 1'b1;
            cnt_d  = cnt_q + 4'd1;
            rcon_d = rcon_next;
            if (cnt_q == 4'(NR)) begin
               state_d = S_FINISH;
               busy_d  = 1'b0;
               ready_d = 1'b1;
               done_d  = 1'b1;
            end
         end
         S_FINISH: begin
            done_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
         rcon_q  <= 8'h01;
         busy_q  <= 1'b0;
         ready_q <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rcon_q  <= rcon_d;
         busy_q  <= busy_d;
         ready_q <= ready_d;
         done_q  <= done_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i <= NR; i++) rk_q[i] <= '0;
      end else if (rk_we) begin
         for (int i = 0; i <= NR; i++) begin
            if (rk_widx == 4'(i)) rk_q[i] <= rk_wdata;
         end
      end
   end

   // Addresses beyond NR match no entry and read as zero
   always_comb begin
      rk_data = '0;
      for (int i = 0; i <= NR; i++) begin
         if (rk_addr == 4'(i)) rk_data = rk_q[i];
      end
   end

   assign busy  = busy_q;
   assign ready = ready_q;
   assign done  = done_q;

`ifdef AES_KEY_STREAM_EN
   logic         strm_valid_q;
   logic [3:0]   strm_idx_q;
   logic [127:0] strm_data_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         strm_valid_q <= 1'b0;
         strm_idx_q   <= 4'd0;
         strm_data_q  <= '0;
      end else begin
         strm_valid_q <= rk_we;
         if (rk_we) begin
            strm_idx_q  <= rk_widx;
            strm_data_q <= rk_wdata;
         end
      end
   end

   assign rk_strm_valid = strm_valid_q;
   assign rk_strm_idx   = strm_idx_q;
   assign rk_strm_data  = strm_data_q;
`endif
endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// tb/tb_aes_key_sched_ctrl.sv - self-checking bench for aes_key_sched_ctrl against FIPS-197 vectors.
`timescale 1ns/1ps
module tb_aes_key_sched_ctrl;
   localparam int NR = 10;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [127:0] key_in;
   logic         busy, ready, done;
   logic [3:0]   rk_addr;
   logic [127:0] rk_data;
`ifdef AES_KEY_STREAM_EN
   logic         strm_valid;
   logic [3:0]   strm_idx;
   logic [127:0] strm_data;
`endif

   always #5 clk = ~clk;

   aes_key_sched_ctrl #(.NR(NR)) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .key_in  (key_in),
      .busy    (busy),
      .ready   (ready),
      .done    (done),
      .rk_addr (rk_addr),
      .rk_data (rk_data)
`ifdef AES_KEY_STREAM_EN
      ,.rk_strm_valid (strm_valid)
      ,.rk_strm_idx   (strm_idx)
      ,.rk_strm_data  (strm_data)
`endif
   );

   logic [127:0] ks [0:1][0:10] = '{
      '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'ha0fafe1788542cb123a339392a6c7605,
        128'hf2c295f27a96b9435935807a7359f67f, 128'h3d80477d4716fe3e1e237e446d7a883b,
        128'hef44a541a8525b7fb671253bdb0bad00, 128'hd4d1c6f87c839d87caf2b8bc11f915bc,
        128'h6d88a37a110b3efddbf98641ca0093fd, 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
        128'head27321b58dbad2312bf5607f8d292f, 128'hac7766f319fadc2128d12941575c006e,
        128'hd014f9a8c9ee2589e13f0cc8b6630ca6},
      '{128'h00000000000000000000000000000000, 128'h62636363626363636263636362636363,
        128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa, 128'h90973450696ccffaf2f457330b0fac99,
        128'hee06da7b876a1581759e42b27e91ee2b, 128'h7f2e2b88f8443e098dda7cbbf34b9290,
        128'hec614b851425758c99ff09376ab49ba7, 128'h217517873550620bacaf6b3cc61bf09b,
        128'h0ef903333ba9613897060a04511dfa9f, 128'hb1d4d8e28a7db9da1d7bb3de4c664941,
        128'hb4ef5bcb3e92e21123e951cf6f8f188e}
   };

   typedef struct {
      int           set;
      logic [3:0]   addr;
      logic [127:0] exp;
   } rd_vec_t;

   rd_vec_t vecs [$];
   int      exp_q [$];
`ifdef AES_KEY_STREAM_EN
   typedef struct {
      logic [3:0]   idx;
      logic [127:0] data;
   } beat_t;
   beat_t strm_q [$];
`endif

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic check_set(input int id);
      foreach (vecs[i]) begin
         if (vecs[i].set == id) begin
            rk_addr = vecs[i].addr;
            #1;
            check($sformatf("rk[%0d] set%0d", vecs[i].addr, id), rk_data, vecs[i].exp);
         end
      end
   endtask

   task automatic run(input int id, input bit hold);
      int edges;
      int busy_cnt;
      bit seen;
      @(negedge clk);
      start  = 1'b1;
      key_in = ks[id][0];
      exp_q.push_back(id);
`ifdef AES_KEY_STREAM_EN
      for (int i = 0; i <= NR; i++) strm_q.push_back('{idx: 4'(i), data: ks[id][i]});
`endif
      @(posedge clk); #1;
      check("busy after start", 128'(busy), 128'(1));
      check("ready drops after start", 128'(ready), 128'(0));
      busy_cnt = 1;
      if (hold) key_in = ~key_in;
      else start = 1'b0;
      edges = 0;
      seen  = 1'b0;
      while (!seen && edges < 40) begin
         @(posedge clk); #1;
         edges++;
         if (hold) key_in = {$urandom, $urandom, $urandom, $urandom};
         if (busy) busy_cnt++;
         if (done) seen = 1'b1;
      end
      check("done latency", 128'(edges), 128'(NR));
      check("busy cycles", 128'(busy_cnt), 128'(NR));
      check("ready at done", 128'(ready), 128'(1));
      @(posedge clk); #1;
      check("done single pulse", 128'(done), 128'(0));
      check("ready held", 128'(ready), 128'(1));
      start = 1'b0;
      @(posedge clk); #1;
      check("no restart from finish", 128'(busy), 128'(0));
      if (exp_q.size() == 0) check("scoreboard empty", 128'(0), 128'(1));
      else check_set(exp_q.pop_front());
   endtask

`ifdef AES_KEY_STREAM_EN
   always @(negedge clk) begin
      if (strm_valid) begin
         if (strm_q.size() == 0) begin
            check("unexpected stream beat", 128'(strm_idx), 128'hffff);
         end else begin
            beat_t b;
            b = strm_q.pop_front();
            check("stream idx", 128'(strm_idx), 128'(b.idx));
            check("stream data", strm_data, b.data);
         end
      end
   end
`endif

   initial begin
      for (int s = 0; s < 2; s++) begin
         for (int a = 0; a <= NR; a++) vecs.push_back('{set: s, addr: 4'(a), exp: ks[s][a]});
         vecs.push_back('{set: s, addr: 4'd11, exp: 128'h0});
         vecs.push_back('{set: s, addr: 4'd15, exp: 128'h0});
      end

      rst = 1'b1; start = 1'b0; key_in = '0; rk_addr = 4'd0;
      repeat (3) @(posedge clk);
      #1;
      check("reset busy", 128'(busy), 128'(0));
      check("reset ready", 128'(ready), 128'(0));
      check("reset done", 128'(done), 128'(0));
      check("reset rk0", rk_data, 128'h0);
      @(negedge clk); rst = 1'b0;
      repeat (2) @(posedge clk);

      run(0, 1'b0);
      run(1, 1'b0);
      run(0, 1'b1);

      // Abort at cycle 5 of an expansion, then restart cleanly
      @(negedge clk);
      start = 1'b1; key_in = ks[0][0];
      exp_q.push_back(0);
      @(posedge clk); #1;
      start = 1'b0;
      repeat (5) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("async rst busy", 128'(busy), 128'(0));
      check("async rst ready", 128'(ready), 128'(0));
      check("async rst done", 128'(done), 128'(0));
`ifdef AES_KEY_STREAM_EN
      check("async rst strm valid", 128'(strm_valid), 128'(0));
      strm_q.delete();
`endif
      exp_q.delete();
      for (int a = 0; a <= NR; a++) begin
         rk_addr = 4'(a);
         #1;
         check($sformatf("rk[%0d] cleared", a), rk_data, 128'h0);
      end
      @(negedge clk); rst = 1'b0;
      repeat (2) @(posedge clk);
      run(1, 1'b0);

`ifdef AES_KEY_STREAM_EN
      repeat (2) @(posedge clk);
      check("stream beats drained", 128'(strm_q.size()), 128'(0));
`endif
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
